// File: rtl/i_cache_pkg.sv
// i_cache_pkg: shared types and helpers for the instruction cache and its refill engine
//   state_t   : refill FSM states
//   off_bits  : offset-field width for a given words-per-line
//   line_base : clears the offset bits of a word address
package i_cache_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    function automatic int off_bits(input int words);
        return $clog2(words);
    endfunction

    function automatic logic [31:0] line_base(input logic [31:0] addr, input int ob);
        return addr & ~((32'd1 << ob) - 32'd1);
    endfunction

endpackage

// File: rtl/i_cache_refill.sv
// i_cache_refill: miss-refill engine fetching one cache line word-by-word from instruction memory
//   clk, rst_n                       : clock, asynchronous active-low reset
//   miss_req, miss_addr, miss_ready  : line-miss request handshake from the cache
//   fill_valid, fill_addr, fill_line : one-cycle fill pulse with the assembled line
//   crit_valid, crit_data            : critical word (only when REFILL_CWF_EN is defined, else 0)
//   mem_rd_en, mem_addr              : single-outstanding read strobe to memory
//   mem_rdata, mem_rvalid            : read return from memory
// Build option: define REFILL_CWF_EN for critical-word-first fetch order.
module i_cache_refill
    import i_cache_pkg::*;
#(
    parameter int ADD_WIDTH      = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 miss_req,
    input  logic [ADD_WIDTH-1:0]                 miss_addr,
    output logic                                 miss_ready,
    output logic                                 fill_valid,
    output logic [ADD_WIDTH-1:0]                 fill_addr,
    output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] fill_line,
    output logic                                 crit_valid,
    output logic [DATA_WIDTH-1:0]                crit_data,
    output logic                                 mem_rd_en,
    output logic [ADD_WIDTH-1:0]                 mem_addr,
    input  logic [DATA_WIDTH-1:0]                mem_rdata,
    input  logic                                 mem_rvalid
);

    localparam int OFF_BITS = off_bits(WORDS_PER_LINE);

    state_t                               state, state_nx;
    logic [ADD_WIDTH-1:0]                 base, base_nx;
    logic [OFF_BITS-1:0]                  cur_off, start_off, count;
    logic [DATA_WIDTH*WORDS_PER_LINE-1:0] line, line_nx, fill_line_q;
    logic [ADD_WIDTH-1:0]                 fill_addr_q;
    logic                                 word_in, last;

    assign base_nx = ADD_WIDTH'(line_base(32'(miss_addr), OFF_BITS));
`ifdef REFILL_CWF_EN
    assign start_off = miss_addr[OFF_BITS-1:0];
`else
    assign start_off = '0;
`endif
    assign word_in    = (state == WAIT) && mem_rvalid;
    assign last       = count == OFF_BITS'(WORDS_PER_LINE - 1);
    assign miss_ready = state == IDLE;
    assign mem_rd_en  = state == REQ;
    assign mem_addr   = mem_rd_en ? (base | ADD_WIDTH'(cur_off)) : '0;
    assign fill_valid = state == DONE;
    assign fill_addr  = fill_addr_q;
    assign fill_line  = fill_line_q;

    always_comb begin
        line_nx = line;
        line_nx[int'(cur_off)*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = miss_req ? REQ : IDLE;
            REQ:     state_nx = WAIT;
            WAIT:    state_nx = mem_rvalid ? (last ? DONE : REQ) : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base        <= '0;
            cur_off     <= '0;
            count       <= '0;
            line        <= '0;
            fill_line_q <= '0;
            fill_addr_q <= '0;
        end else begin
            if (miss_ready && miss_req) begin
                base    <= base_nx;
                cur_off <= start_off;
                count   <= '0;
            end
            if (word_in) begin
                line    <= line_nx;
                cur_off <= cur_off + OFF_BITS'(1);
                count   <= count + OFF_BITS'(1);
                // fill outputs only change on completion so they hold across the next refill
                if (last) begin
                    fill_line_q <= line_nx;
                    fill_addr_q <= base;
                end
            end
        end
    end

`ifdef REFILL_CWF_EN
    logic                  crit_v;
    logic [DATA_WIDTH-1:0] crit_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crit_v <= 1'b0;
            crit_d <= '0;
        end else begin
            crit_v <= word_in && (count == '0);
            if (word_in && (count == '0)) crit_d <= mem_rdata;
        end
    end
    assign crit_valid = crit_v;
    assign crit_data  = crit_d;
`else
    assign crit_valid = 1'b0;
    assign crit_data  = '0;
`endif

endmodule
